// File: rtl/cpu_run_controller.sv
// Debounced step/run controller producing a per-cycle CPU clock enable (single/N-step, free run, run-to-breakpoint).
// Enable rises the cycle after an accepted press; no backpressure, halt_req or a press forces enable low that cycle.
module cpu_run_controller #(
  parameter int NUM_BREAKPOINTS = 4,
  parameter int PC_WIDTH        = 32,
  parameter int STEP_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int IDX_W = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  button,
  input  logic [1:0]            mode,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic                  halt_req,
  input  logic                  bp_we,
  input  logic [IDX_W-1:0]      bp_index,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic                  bp_valid,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  cpu_enable,
  output logic                  running,
  output logic                  halted_on_bp,
  output logic [IDX_W-1:0]      bp_hit_index,
  output logic [31:0]           retired_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STEP, RUN, RUN_BP} state_t;

  state_t                   state;
  logic                     sync_q1, sync_q2, db_level;
  logic [DB_W-1:0]          db_cnt;
  logic [STEP_WIDTH-1:0]    remaining;
  logic                     first;
  logic [PC_WIDTH-1:0]      bp_addr_q [NUM_BREAKPOINTS];
  logic [NUM_BREAKPOINTS-1:0] bp_valid_q;
  logic                     bp_match;
  logic [IDX_W-1:0]         bp_idx;
  logic                     db_flip, go, stop_req, bp_wr_ok;

  assign db_flip  = (sync_q2 != db_level) && (db_cnt == DB_LAST);
  assign go       = db_flip && sync_q2;
  assign stop_req = halt_req || go;
  assign running  = (state != IDLE);
  assign bp_wr_ok = bp_we && ({1'b0, bp_index} < (IDX_W + 1)'(NUM_BREAKPOINTS));

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == pc)) begin
        bp_match = 1'b1;
        bp_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cpu_enable = 1'b0;
    case (state)
      STEP, RUN: cpu_enable = 1'b1;
      RUN_BP:    cpu_enable = !(bp_match && !first);
      default:   cpu_enable = 1'b0;
    endcase
    if (stop_req) cpu_enable = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (bp_wr_ok) bp_addr_q[bp_index] <= bp_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      db_level      <= 1'b0;
      db_cnt        <= '0;
      remaining     <= '0;
      first         <= 1'b0;
      bp_valid_q    <= '0;
      halted_on_bp  <= 1'b0;
      bp_hit_index  <= '0;
      retired_count <= '0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
      if (sync_q2 == db_level) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt   <= '0;
        db_level <= sync_q2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (bp_wr_ok) bp_valid_q[bp_index] <= bp_valid;
      if (cpu_enable) retired_count <= retired_count + 32'd1;

      case (state)
        IDLE: begin
          if (go) begin
            halted_on_bp <= 1'b0;
            case (mode)
              2'd0: begin
                remaining <= STEP_WIDTH'(1);
                state     <= STEP;
              end
              2'd1: begin
                if (step_count != '0) begin
                  remaining <= step_count;
                  state     <= STEP;
                end
              end
              2'd2: state <= RUN;
              default: begin
                first <= 1'b1;
                state <= RUN_BP;
              end
            endcase
          end
        end
        STEP: begin
          if (stop_req) begin
            state <= IDLE;
          end else if (cpu_enable) begin
            remaining <= remaining - 1'b1;
            if (remaining == STEP_WIDTH'(1)) state <= IDLE;
          end
        end
        RUN: begin
          if (stop_req) state <= IDLE;
        end
        default: begin
          first <= 1'b0;
          if (stop_req) begin
            state <= IDLE;
          end else if (bp_match && !first) begin
            state        <= IDLE;
            halted_on_bp <= 1'b1;
            bp_hit_index <= bp_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios with randomized lengths and breakpoint tables.
module tb_cpu_run_controller;

  localparam int NBP = 4;
  localparam int PCW = 32;
  localparam int SW  = 16;
  localparam int DB  = 4;

  logic           clock = 1'b0;
  logic           reset, button, halt_req, bp_we, bp_valid;
  logic [1:0]     mode;
  logic [SW-1:0]  step_count;
  logic [1:0]     bp_index;
  logic [PCW-1:0] bp_addr, pc;
  logic           cpu_enable, running, halted_on_bp;
  logic [1:0]     bp_hit_index;
  logic [31:0]    retired_count;

  cpu_run_controller #(
    .NUM_BREAKPOINTS(NBP), .PC_WIDTH(PCW), .STEP_WIDTH(SW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .button(button), .mode(mode),
    .step_count(step_count), .halt_req(halt_req), .bp_we(bp_we),
    .bp_index(bp_index), .bp_addr(bp_addr), .bp_valid(bp_valid), .pc(pc),
    .cpu_enable(cpu_enable), .running(running), .halted_on_bp(halted_on_bp),
    .bp_hit_index(bp_hit_index), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_en, n_cyc, first_en, en_runs;
  bit prev_en, ever_run;
  longint exp_retired;
  logic [PCW-1:0] m_addr [NBP];
  bit m_valid [NBP];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_en = 0; n_cyc = 0; first_en = -1; en_runs = 0; prev_en = 0; ever_run = 0;
  endtask

  // One clock: sample at negedge, advance the modelled CPU pc after the edge.
  task automatic cyc();
    bit e;
    @(negedge clock);
    e = cpu_enable;
    n_cyc++;
    if (running) ever_run = 1;
    if (e) begin
      n_en++;
      if (first_en < 0) first_en = n_cyc;
      if (!prev_en) en_runs++;
    end
    prev_en = e;
    @(posedge clock);
    #1;
    if (e) pc = pc + 4;
  endtask

  task automatic cycles(int n);
    repeat (n) cyc();
  endtask

  task automatic press_run(int hold, int target, int limit);
    button = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (i == hold) button = 1'b0;
      if (target > 0 && n_en >= target) break;
      cyc();
    end
    button = 1'b0;
  endtask

  task automatic write_bp(int idx, logic [PCW-1:0] a, bit v);
    bp_we = 1'b1; bp_index = 2'(idx); bp_addr = a; bp_valid = v;
    cyc();
    bp_we = 1'b0;
    m_addr[idx] = a;
    m_valid[idx] = v;
  endtask

  // Enables before halting: first pc past the start that hits a valid entry.
  function automatic int exp_halt(logic [PCW-1:0] start, int limit, output int hit);
    for (int k = 1; k <= limit; k++)
      for (int i = 0; i < NBP; i++)
        if (m_valid[i] && m_addr[i] == start + 32'(4 * k)) begin
          hit = i;
          return k;
        end
    hit = 0;
    return -1;
  endfunction

  task automatic stop_with_halt();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("halt_cycle_en", prev_en, 0);
    cycles(15);
  endtask

  task automatic bp_run(string tag);
    int k, h;
    logic [PCW-1:0] start;
    start = pc;
    k = exp_halt(start, 40, h);
    clear_obs();
    mode = 2'd3;
    press_run(8, 0, 60);
    chk({tag, "_en"}, n_en, k);
    chk({tag, "_halted"}, halted_on_bp, 1);
    chk({tag, "_idx"}, bp_hit_index, h);
    chk({tag, "_pc"}, pc, start + 32'(4 * k));
    exp_retired += k;
    chk({tag, "_ret"}, retired_count, exp_retired);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, base;
    reset = 1'b1; button = 1'b0; halt_req = 1'b0; bp_we = 1'b0; bp_valid = 1'b0;
    bp_addr = '0; bp_index = '0; mode = '0; step_count = '0; pc = '0;
    exp_retired = 0;
    for (int i = 0; i < NBP; i++) begin m_valid[i] = 0; m_addr[i] = '0; end
    @(posedge clock); #1;
    cycles(3);
    chk("rst_en", cpu_enable, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted_on_bp, 0);
    chk("rst_idx", bp_hit_index, 0);
    chk("rst_retired", retired_count, 0);
    reset = 1'b0;
    cycles(2);

    clear_obs();
    press_run(2, 0, 20);
    chk("glitch_en", n_en, 0);
    chk("glitch_running", ever_run, 0);

    mode = 2'd0;
    clear_obs();
    press_run(10, 0, 25);
    chk("s0_en", n_en, 1);
    chk("s0_latency", first_en, DB + 3);
    exp_retired += 1;
    chk("s0_ret", retired_count, exp_retired);
    chk("s0_running", running, 0);

    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 30);
      mode = 2'd1; step_count = SW'(n);
      clear_obs();
      button = 1'b1; cycles(8); button = 1'b0;
      mode = 2'd2; step_count = SW'($urandom);
      cycles(n + 20);
      chk("sN_en", n_en, n);
      chk("sN_contig", en_runs, 1);
      chk("sN_latency", first_en, DB + 3);
      exp_retired += n;
      chk("sN_ret", retired_count, exp_retired);
      chk("sN_running", running, 0);
    end

    mode = 2'd1; step_count = '0;
    clear_obs();
    press_run(8, 0, 25);
    chk("s0cnt_en", n_en, 0);
    chk("s0cnt_running", ever_run, 0);

    r = $urandom_range(10, 40);
    mode = 2'd2;
    clear_obs();
    press_run(8, r, r + 30);
    chk("run_reach", n_en, r);
    stop_with_halt();
    chk("run_halt_en", n_en, r);
    chk("run_halt_running", running, 0);
    exp_retired += r;
    chk("run_halt_ret", retired_count, exp_retired);

    r = $urandom_range(10, 40);
    clear_obs();
    press_run(8, r, r + 30);
    cycles(12);
    chk("run2_reach", n_en, r + 12);
    base = r + 12;
    button = 1'b1; cycles(8); button = 1'b0;
    cycles(20);
    chk("run_go_en", n_en, base + DB + 1);
    chk("run_go_running", running, 0);
    exp_retired += base + DB + 1;
    chk("run_go_ret", retired_count, exp_retired);

    pc = '0;
    write_bp(2, 32'h10, 1);
    bp_run("bp2");
    clear_obs();
    press_run(8, 10, 40);
    chk("resume_en", n_en, 10);
    chk("resume_first", first_en, DB + 3);
    chk("resume_halted", halted_on_bp, 0);
    stop_with_halt();
    chk("resume_pc", pc, 32'h10 + 32'd40);
    exp_retired += 10;
    chk("resume_ret", retired_count, exp_retired);

    write_bp(2, 32'h10, 0);
    write_bp(0, 32'h8, 1);
    write_bp(3, 32'h8, 1);
    pc = '0;
    bp_run("dual0");
    write_bp(0, 32'h8, 0);
    pc = '0;
    bp_run("dual3");

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NBP; i++)
        write_bp(i, 32'(4 * $urandom_range(1, 12)), bit'($urandom_range(0, 1)));
      write_bp($urandom_range(0, NBP - 1), 32'(4 * $urandom_range(1, 12)), 1);
      pc = '0;
      bp_run("bprand");
    end

    mode = 2'd2;
    clear_obs();
    press_run(8, 10, 40);
    reset = 1'b1;
    cyc();
    chk("mrst_en", cpu_enable, 0);
    chk("mrst_running", running, 0);
    chk("mrst_halted", halted_on_bp, 0);
    chk("mrst_idx", bp_hit_index, 0);
    chk("mrst_retired", retired_count, 0);
    reset = 1'b0;
    exp_retired = 0;
    for (int i = 0; i < NBP; i++) m_valid[i] = 0;
    cycles(12);

    pc = '0; mode = 2'd3;
    clear_obs();
    press_run(8, 6, 40);
    chk("mrst_bp_en", n_en, 6);
    chk("mrst_bp_running", running, 1);
    chk("mrst_bp_halted", halted_on_bp, 0);
    stop_with_halt();
    exp_retired += 6;
    chk("mrst_bp_ret", retired_count, exp_retired);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
